// File: rtl/mem_bus_responder_if.sv
// rtl/mem_bus_responder_if.sv - pipeline MEM-stage bus between the control signal generator and the responder
interface mem_bus_responder_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  mem_read;
    logic                  mem_write;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  ready;
    logic                  stall;
    logic                  error;

    modport master (
        output mem_read, mem_write, address, data_in,
        input  data_out, ready, stall, error
    );

    modport slave (
        input  mem_read, mem_write, address, data_in,
        output data_out, ready, stall, error
    );
endinterface

// File: rtl/mem_bus_responder.sv
// rtl/mem_bus_responder.sv - wait-state data memory responder; MEM_WAIT_STATES_EN enables WAIT_CYCLES wait states
module mem_bus_responder #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 8,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_bus_responder_if.slave   bus
);
    localparam int          IDX_W   = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = 32'(MEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  ready_q;
    logic                  error_q;

    // A request is exactly one strobe; both together is a protocol fault.
    logic one_req;
    logic both_req;
    assign one_req  = bus.mem_read ^ bus.mem_write;
    assign both_req = bus.mem_read & bus.mem_write;

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
        return 32'(a) < DEPTH_U;
    endfunction

    logic                  mem_we;
    logic [IDX_W-1:0]      mem_widx;
    logic [DATA_WIDTH-1:0] mem_wdata;

`ifdef MEM_WAIT_STATES_EN
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    logic [CNT_W-1:0]      count;
    logic                  lat_write;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [DATA_WIDTH-1:0] lat_data;
    logic                  lat_valid;
    logic                  last_wait;

    assign lat_valid = in_range(lat_addr);
    assign last_wait = (state == ACCESS) && (count == '0);

    // The array is touched only on the final wait-state edge, from the latched transaction.
    assign mem_we    = !reset && last_wait && lat_write && lat_valid;
    assign mem_widx  = lat_addr[IDX_W-1:0];
    assign mem_wdata = lat_data;

    assign bus.stall = !reset && (((state == IDLE) && one_req) || (state == ACCESS));

    // Control FSM: accept, count down wait states, complete with registered ready/error/data_out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            lat_write  <= 1'b0;
            lat_addr   <= '0;
            lat_data   <= '0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (both_req) begin
                        error_q <= 1'b1;
                    end else if (one_req) begin
                        lat_write <= bus.mem_write;
                        lat_addr  <= bus.address;
                        lat_data  <= bus.data_in;
                        count     <= CNT_W'(WAIT_CYCLES - 1);
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (count == '0) begin
                        if (!lat_write) begin
                            data_out_q <= lat_valid ? mem[lat_addr[IDX_W-1:0]] : '0;
                        end
                        ready_q <= 1'b1;
                        error_q <= !lat_valid;
                        state   <= DONE;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                DONE: begin
                    // Strobes are still high here; returning unconditionally avoids re-acceptance.
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic req_valid;
    assign req_valid = in_range(bus.address);

    // Without wait states the array is accessed on the acceptance edge straight from the bus.
    assign mem_we    = !reset && (state == IDLE) && one_req && bus.mem_write && req_valid;
    assign mem_widx  = bus.address[IDX_W-1:0];
    assign mem_wdata = bus.data_in;

    assign bus.stall = !reset && (state == IDLE) && one_req;

    // Control FSM: accept and access in one edge, then a single DONE cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (both_req) begin
                        error_q <= 1'b1;
                    end else if (one_req) begin
                        if (!bus.mem_write) begin
                            data_out_q <= req_valid ? mem[bus.address[IDX_W-1:0]] : '0;
                        end
                        ready_q <= 1'b1;
                        error_q <= !req_valid;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

    // Storage array; deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.ready    = ready_q;
    assign bus.error    = error_q;
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb/tb_mem_bus_responder.sv - randomized self-checking bench for mem_bus_responder
module tb_mem_bus_responder;
    localparam int AW    = 16;
    localparam int DW    = 8;
    localparam int DEPTH = 256;
    localparam int WC    = 2;
`ifdef MEM_WAIT_STATES_EN
    localparam int LAT   = WC + 1;
    localparam int RST_C = (WC >= 2) ? 2 : 1;
`else
    localparam int LAT   = 1;
    localparam int RST_C = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_bus_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    mem_bus_responder #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (DEPTH),
        .WAIT_CYCLES(WC)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] ref_dout;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return 32'(a) < 32'(DEPTH);
    endfunction

    // One complete transaction: strobe held from request through DONE, address/data scrambled after acceptance.
    task automatic access(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        logic valid;
        valid = addr_ok(addr);
        next_cycle();
        bus.mem_read  = !wr;
        bus.mem_write = wr;
        bus.address   = addr;
        bus.data_in   = wdata;
        #1;
        for (int c = 0; c <= LAT; c++) begin
            if (c > 0) begin
                next_cycle();
                bus.address = AW'($urandom);
                bus.data_in = DW'($urandom);
                #1;
            end
            if (c == LAT) begin
                if (wr && valid) ref_mem[addr[7:0]] = wdata;
                if (!wr) ref_dout = valid ? ref_mem[addr[7:0]] : '0;
            end
            chk("stall",    32'(bus.stall),    32'(c < LAT));
            chk("ready",    32'(bus.ready),    32'(c == LAT));
            chk("error",    32'(bus.error),    32'((c == LAT) && !valid));
            chk("data_out", 32'(bus.data_out), 32'(ref_dout));
        end
    endtask

    task automatic idle_cycle();
        next_cycle();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        #1;
        chk("idle_stall", 32'(bus.stall), 32'd0);
        chk("idle_ready", 32'(bus.ready), 32'd0);
        chk("idle_error", 32'(bus.error), 32'd0);
        chk("idle_dout",  32'(bus.data_out), 32'(ref_dout));
    endtask

    // Both strobes in IDLE: nothing accepted, error one cycle later.
    task automatic both_strobes(input logic [AW-1:0] addr);
        next_cycle();
        bus.mem_read  = 1'b1;
        bus.mem_write = 1'b1;
        bus.address   = addr;
        bus.data_in   = DW'($urandom);
        #1;
        chk("both_stall", 32'(bus.stall), 32'd0);
        chk("both_ready", 32'(bus.ready), 32'd0);
        next_cycle();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        #1;
        chk("both_err_pulse", 32'(bus.error), 32'd1);
        chk("both_stall2",    32'(bus.stall), 32'd0);
        chk("both_ready2",    32'(bus.ready), 32'd0);
    endtask

    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            r;

    initial begin
        reset         = 1'b1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.address   = '0;
        bus.data_in   = '0;
        ref_dout      = '0;
        #1;
        chk("rst_stall", 32'(bus.stall),    32'd0);
        chk("rst_ready", 32'(bus.ready),    32'd0);
        chk("rst_error", 32'(bus.error),    32'd0);
        chk("rst_dout",  32'(bus.data_out), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        idle_cycle();

        for (int i = 0; i < DEPTH; i++) begin
            access(1'b1, AW'(i), DW'($urandom));
        end

        access(1'b1, 16'h0010, 8'h3C);
        access(1'b0, 16'h0010, 8'h00);
        chk("rd_0x10", 32'(bus.data_out), 32'h3C);
        idle_cycle();

        both_strobes(16'h0020);
        idle_cycle();
        access(1'b0, 16'h0020, 8'h00);

        access(1'b1, 16'h0100, 8'h55);
        access(1'b0, 16'h0100, 8'h00);
        chk("rd_oob_zero", 32'(bus.data_out), 32'h00);
        idle_cycle();

        next_cycle();
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b1;
        bus.address   = 16'h0005;
        bus.data_in   = 8'hAA;
        for (int c = 1; c <= RST_C; c++) next_cycle();
`ifndef MEM_WAIT_STATES_EN
        ref_mem[5] = 8'hAA;
`endif
        reset = 1'b1;
        #1;
        ref_dout = '0;
        chk("midrst_stall", 32'(bus.stall),    32'd0);
        chk("midrst_ready", 32'(bus.ready),    32'd0);
        chk("midrst_error", 32'(bus.error),    32'd0);
        chk("midrst_dout",  32'(bus.data_out), 32'd0);
        bus.mem_write = 1'b0;
        next_cycle();
        reset = 1'b0;
        idle_cycle();
        access(1'b0, 16'h0005, 8'h00);

        access(1'b0, 16'h0001, 8'h00);
        access(1'b0, 16'h0002, 8'h00);
        idle_cycle();

        for (int i = 0; i < 200; i++) begin
            r = int'($urandom_range(0, 11));
            if (r == 0) a = AW'($urandom);
            else if (r == 1) a = AW'(DEPTH + int'($urandom_range(0, 255)));
            else a = AW'($urandom_range(0, DEPTH - 1));
            d = DW'($urandom);
            if (r == 2) idle_cycle();
            else if (r == 3) both_strobes(a);
            else access($urandom_range(0, 1) == 1, a, d);
        end
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
